// File: rtl/td4_ctrl_pkg.sv
// Shared definitions for the TD4 execution controller: state encodings,
// speed-select encodings and the instruction counter width.
package td4_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_HALT  = 2'd1,
    S_RUN   = 2'd2,
    S_STEP  = 2'd3
  } ctrl_state_e;

  // speed_sel: full rate, DIV_FAST, and two codes that both mean DIV_SLOW
  localparam logic [1:0] SPD_FULL     = 2'd0;
  localparam logic [1:0] SPD_FAST     = 2'd1;
  localparam logic [1:0] SPD_SLOW     = 2'd2;
  localparam logic [1:0] SPD_SLOW_ALT = 2'd3;

  localparam int INSN_CNT_W = 16;

endpackage

// File: rtl/td4_tick_div.sv
// Rate divider for the TD4 execution controller. Produces a combinational
// tick once every N cycles (N = 1, DIV_FAST or DIV_SLOW). The cycle in which
// clear is high counts as position 0, so the first tick after a clear lands
// N-1 cycles later. speed_sel is only sampled at position 0, so a rate change
// takes effect at the next wrap.
module td4_tick_div
  import td4_ctrl_pkg::*;
#(
  parameter int DIV_FAST = 4,
  parameter int DIV_SLOW = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [1:0] speed_sel,
  output logic       tick
);

  localparam int MAX_DIV = (DIV_FAST > DIV_SLOW) ? DIV_FAST : DIV_SLOW;
  localparam int CW      = $clog2(MAX_DIV + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] n_q;
  logic [CW-1:0] pos;
  logic [CW-1:0] n;

  function automatic logic [CW-1:0] div_for(input logic [1:0] sel);
    case (sel)
      SPD_FULL: div_for = CW'(1);
      SPD_FAST: div_for = CW'(DIV_FAST);
      default:  div_for = CW'(DIV_SLOW);
    endcase
  endfunction

  // Current position in the period and the divisor in force for it
  always_comb begin
    pos  = clear ? '0 : cnt_q;
    n    = (pos == '0) ? div_for(speed_sel) : n_q;
    tick = (pos == n - CW'(1));
  end

  // Advance the position, wrapping after the tick; hold the sampled divisor
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      n_q   <= CW'(1);
    end else begin
      cnt_q <= tick ? '0 : pos + CW'(1);
      n_q   <= n;
    end
  end

endmodule

// File: rtl/td4_exec_ctrl.sv
// Execution controller for the 4-bit TD4 core: owns the core reset and a
// one-cycle clock enable, and implements run / halt / single-step / divided
// rate execution. Optional breakpoint support is compiled in with the macro
// TD4_BREAKPOINT_EN (adds bp_en, bp_addr and bp_hit).
module td4_exec_ctrl
  import td4_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int DIV_FAST   = 4,
  parameter int DIV_SLOW   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_run,
  input  logic                  cmd_halt,
  input  logic                  cmd_step,
  input  logic                  cmd_reset,
  input  logic [1:0]            speed_sel,
  input  logic [3:0]            pc,
`ifdef TD4_BREAKPOINT_EN
  input  logic                  bp_en,
  input  logic [3:0]            bp_addr,
  output logic                  bp_hit,
`endif
  output logic                  cpu_ce,
  output logic                  cpu_rst_n,
  output logic [1:0]            state,
  output logic [INSN_CNT_W-1:0] insn_cnt
);

  localparam int              RCW      = $clog2(RST_CYCLES) + 1;
  localparam logic [RCW-1:0]  RST_LAST = RCW'(RST_CYCLES - 1);

  ctrl_state_e    state_q;
  ctrl_state_e    state_d;
  logic [RCW-1:0] rcnt_q;
  logic [RCW-1:0] rcnt_d;
  logic           tick;
  logic           div_clear;
  logic           ce_d;
  logic           rst_n_d;
  logic           bp_trip;

  assign state = state_q;

  td4_tick_div #(
    .DIV_FAST (DIV_FAST),
    .DIV_SLOW (DIV_SLOW)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .clear     (div_clear),
    .speed_sel (speed_sel),
    .tick      (tick)
  );

`ifdef TD4_BREAKPOINT_EN
  logic       first_q;
  logic [3:0] bp_pc;

  // cpu_ce is registered, so the pulse decided now executes next cycle. If
  // the core is being enabled this cycle its pc will already have advanced
  // by then; compare against that address (sequential flow assumed).
  assign bp_pc   = cpu_ce ? pc + 4'd1 : pc;
  assign bp_trip = (state_q == S_RUN) && !cmd_reset && !cmd_halt && tick &&
                   bp_en && (bp_pc == bp_addr) && !first_q;

  // Exempt the first pulse after entering run; sticky breakpoint flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      first_q <= 1'b0;
      bp_hit  <= 1'b0;
    end else begin
      if (ce_d)           first_q <= 1'b0;
      else if (div_clear) first_q <= 1'b1;
      if (bp_trip)                               bp_hit <= 1'b1;
      else if (cmd_run || cmd_step || cmd_reset) bp_hit <= 1'b0;
    end
  end
`else
  logic pc_unused;
  assign pc_unused = ^pc;
  assign bp_trip   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_RESET;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Next-state logic; cmd_reset overrides everything, halt beats step beats run
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: if (rcnt_q == RST_LAST) state_d = S_HALT;
      S_HALT: begin
        if (cmd_halt)      state_d = S_HALT;
        else if (cmd_step) state_d = S_STEP;
        else if (cmd_run)  state_d = S_RUN;
      end
      S_RUN: begin
        if (cmd_halt)     state_d = S_HALT;
        else if (bp_trip) state_d = S_HALT;
      end
      S_STEP:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
    if (cmd_reset) state_d = S_RESET;
  end

  // Output decode for the next cycle, divider clear and reset counter
  always_comb begin
    div_clear = (state_q != S_RUN) && (state_d == S_RUN);
    ce_d      = (state_d == S_STEP) || ((state_d == S_RUN) && tick);
    rst_n_d   = (state_d != S_RESET);
    rcnt_d    = ((state_q == S_RESET) && !cmd_reset) ? rcnt_q + RCW'(1) : '0;
  end

  // Registered outputs; insn_cnt survives cmd_reset and wraps naturally
  always_ff @(posedge clk) begin
    if (!rst) begin
      cpu_ce    <= 1'b0;
      cpu_rst_n <= 1'b0;
      insn_cnt  <= '0;
    end else begin
      cpu_ce    <= ce_d;
      cpu_rst_n <= rst_n_d;
      if (cpu_ce) insn_cnt <= insn_cnt + INSN_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_td4_exec_ctrl.sv
// Directed testbench for td4_exec_ctrl. Breakpoint scenario is compiled in
// when TD4_BREAKPOINT_EN is defined.
module tb_td4_exec_ctrl;
  import td4_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_run, cmd_halt, cmd_step, cmd_reset;
  logic [1:0]  speed_sel;
  logic [3:0]  pc;
  logic        cpu_ce, cpu_rst_n;
  logic [1:0]  state;
  logic [15:0] insn_cnt;
`ifdef TD4_BREAKPOINT_EN
  logic        bp_en;
  logic [3:0]  bp_addr;
  logic        bp_hit;
`endif

  int checks   = 0;
  int failures = 0;

  td4_exec_ctrl #(.RST_CYCLES(4), .DIV_FAST(4), .DIV_SLOW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_run   (cmd_run),
    .cmd_halt  (cmd_halt),
    .cmd_step  (cmd_step),
    .cmd_reset (cmd_reset),
    .speed_sel (speed_sel),
    .pc        (pc),
`ifdef TD4_BREAKPOINT_EN
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .bp_hit    (bp_hit),
`endif
    .cpu_ce    (cpu_ce),
    .cpu_rst_n (cpu_rst_n),
    .state     (state),
    .insn_cnt  (insn_cnt)
  );

  always #5 clk = ~clk;

  // Minimal core model: pc advances on every enabled cycle
  always @(posedge clk) begin
    if (!cpu_rst_n) pc <= 4'd0;
    else if (cpu_ce) pc <= pc + 4'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b0;
    tick();
    tick();
    checks++; if (state !== S_RESET) begin failures++; $display("FAIL rst_state: got %0d want %0d", state, S_RESET); end
    checks++; if (cpu_rst_n !== 1'b0) begin failures++; $display("FAIL rst_cpu_rst_n: got %0b want 0", cpu_rst_n); end
    checks++; if (cpu_ce !== 1'b0) begin failures++; $display("FAIL rst_cpu_ce: got %0b want 0", cpu_ce); end
    checks++; if (insn_cnt !== 16'h0) begin failures++; $display("FAIL rst_insn_cnt: got %0h want 0", insn_cnt); end
`ifdef TD4_BREAKPOINT_EN
    checks++; if (bp_hit !== 1'b0) begin failures++; $display("FAIL rst_bp_hit: got %0b want 0", bp_hit); end
`endif
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && cpu_rst_n !== 1'b1; i++) begin
      n++;
      tick();
    end
    checks++; if (n != 4) begin failures++; $display("FAIL rst_low_cycles: got %0d want 4", n); end
    checks++; if (state !== S_HALT) begin failures++; $display("FAIL rst_to_halt: got %0d want %0d", state, S_HALT); end
    checks++; if (insn_cnt !== 16'h0) begin failures++; $display("FAIL rst_insn_after: got %0h want 0", insn_cnt); end
  endtask

  task automatic test_step();
    for (int s = 0; s < 3; s++) begin
      checks++; if (cpu_ce !== 1'b0) begin failures++; $display("FAIL step_pre_ce[%0d]: got %0b want 0", s, cpu_ce); end
      cmd_step = 1'b1;
      tick();
      cmd_step = 1'b0;
      checks++; if (cpu_ce !== 1'b1) begin failures++; $display("FAIL step_ce[%0d]: got %0b want 1", s, cpu_ce); end
      checks++; if (state !== S_STEP) begin failures++; $display("FAIL step_state[%0d]: got %0d want %0d", s, state, S_STEP); end
      tick();
      checks++; if (cpu_ce !== 1'b0) begin failures++; $display("FAIL step_ce_drop[%0d]: got %0b want 0", s, cpu_ce); end
      checks++; if (state !== S_HALT) begin failures++; $display("FAIL step_halt[%0d]: got %0d want %0d", s, state, S_HALT); end
      tick(); tick(); tick();
    end
    checks++; if (insn_cnt !== 16'd3) begin failures++; $display("FAIL step_insn_cnt: got %0d want 3", insn_cnt); end
  endtask

  task automatic test_div_run();
    logic exp_ce;
    speed_sel = 2'd1;
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      exp_ce = (k % 4 == 0) && (k <= 16);
      checks++; if (cpu_ce !== exp_ce) begin failures++; $display("FAIL div_ce@%0d: got %0b want %0b", k, cpu_ce, exp_ce); end
      if (k == 1) begin
        checks++; if (state !== S_RUN) begin failures++; $display("FAIL div_state_run: got %0d want %0d", state, S_RUN); end
      end
      cmd_halt = (k == 19);
      tick();
    end
    cmd_halt = 1'b0;
    checks++; if (state !== S_HALT) begin failures++; $display("FAIL div_state_halt: got %0d want %0d", state, S_HALT); end
    checks++; if (insn_cnt !== 16'd7) begin failures++; $display("FAIL div_insn_cnt: got %0d want 7", insn_cnt); end
  endtask

  task automatic test_coincide();
    int n;
    speed_sel = 2'd0;
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (cpu_ce !== 1'b1) begin failures++; $display("FAIL co_run_ce@%0d: got %0b want 1", k, cpu_ce); end
      if (k < 2) tick();
    end
    cmd_halt = 1'b1;
    cmd_step = 1'b1;
    tick();
    cmd_halt = 1'b0;
    cmd_step = 1'b0;
    checks++; if (state !== S_HALT) begin failures++; $display("FAIL co_halt_state: got %0d want %0d", state, S_HALT); end
    checks++; if (cpu_ce !== 1'b0) begin failures++; $display("FAIL co_halt_ce: got %0b want 0", cpu_ce); end
    tick();
    checks++; if (cpu_ce !== 1'b0 || state !== S_HALT) begin failures++; $display("FAIL co_no_step: got ce=%0b state=%0d want ce=0 state=%0d", cpu_ce, state, S_HALT); end
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    tick();
    checks++; if (cpu_ce !== 1'b1) begin failures++; $display("FAIL co_rerun_ce: got %0b want 1", cpu_ce); end
    cmd_reset = 1'b1;
    tick();
    cmd_reset = 1'b0;
    checks++; if (cpu_ce !== 1'b0) begin failures++; $display("FAIL co_reset_ce: got %0b want 0", cpu_ce); end
    checks++; if (state !== S_RESET) begin failures++; $display("FAIL co_reset_state: got %0d want %0d", state, S_RESET); end
    n = 0;
    for (int i = 0; i < 20 && cpu_rst_n !== 1'b1; i++) begin
      n++;
      tick();
    end
    checks++; if (n != 4) begin failures++; $display("FAIL co_reset_low: got %0d want 4", n); end
    checks++; if (state !== S_HALT) begin failures++; $display("FAIL co_reset_halt: got %0d want %0d", state, S_HALT); end
    checks++; if (insn_cnt !== 16'd12) begin failures++; $display("FAIL co_insn_kept: got %0d want 12", insn_cnt); end
  endtask

  task automatic test_back_to_back();
    int n;
    cmd_step = 1'b1;
    tick();
    checks++; if (cpu_ce !== 1'b1) begin failures++; $display("FAIL b2b_ce1: got %0b want 1", cpu_ce); end
    tick();
    cmd_step = 1'b0;
    checks++; if (cpu_ce !== 1'b0 || state !== S_HALT) begin failures++; $display("FAIL b2b_ignored: got ce=%0b state=%0d want ce=0 state=%0d", cpu_ce, state, S_HALT); end
    tick();
    checks++; if (cpu_ce !== 1'b0) begin failures++; $display("FAIL b2b_quiet: got %0b want 0", cpu_ce); end
    cmd_run = 1'b1;
    cmd_step = 1'b1;
    tick();
    cmd_run = 1'b0;
    cmd_step = 1'b0;
    checks++; if (state !== S_STEP || cpu_ce !== 1'b1) begin failures++; $display("FAIL b2b_step_over_run: got state=%0d ce=%0b want state=%0d ce=1", state, cpu_ce, S_STEP); end
    tick();
    checks++; if (state !== S_HALT) begin failures++; $display("FAIL b2b_step_done: got %0d want %0d", state, S_HALT); end
    cmd_reset = 1'b1;
    tick();
    cmd_reset = 1'b0;
    n = 0;
    for (int i = 0; i < 30 && cpu_rst_n !== 1'b1; i++) begin
      n++;
      cmd_reset = (n == 2);
      tick();
    end
    cmd_reset = 1'b0;
    checks++; if (n != 6) begin failures++; $display("FAIL b2b_reset_restart: got %0d want 6", n); end
    checks++; if (insn_cnt !== 16'd14) begin failures++; $display("FAIL b2b_insn_cnt: got %0d want 14", insn_cnt); end
  endtask

`ifdef TD4_BREAKPOINT_EN
  task automatic test_breakpoint();
    bp_en = 1'b1;
    bp_addr = 4'd5;
    speed_sel = 2'd0;
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    for (int i = 0; i < 40 && state !== S_HALT; i++) tick();
    checks++; if (state !== S_HALT) begin failures++; $display("FAIL bp_halt: got %0d want %0d", state, S_HALT); end
    checks++; if (pc !== 4'd5) begin failures++; $display("FAIL bp_pc: got %0d want 5", pc); end
    checks++; if (bp_hit !== 1'b1) begin failures++; $display("FAIL bp_hit_set: got %0b want 1", bp_hit); end
    checks++; if (cpu_ce !== 1'b0) begin failures++; $display("FAIL bp_ce: got %0b want 0", cpu_ce); end
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    checks++; if (bp_hit !== 1'b0) begin failures++; $display("FAIL bp_hit_clear: got %0b want 0", bp_hit); end
    tick();
    checks++; if (pc !== 4'd6) begin failures++; $display("FAIL bp_resume_pc: got %0d want 6", pc); end
    cmd_halt = 1'b1;
    tick();
    cmd_halt = 1'b0;
    bp_en = 1'b0;
  endtask
`endif

  task automatic test_wrap();
    logic [15:0] exp_cnt;
    speed_sel = 2'd0;
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    for (int i = 0; i < 70000 && insn_cnt !== 16'hFFFD; i++) tick();
    checks++; if (insn_cnt !== 16'hFFFD) begin failures++; $display("FAIL wrap_reach: got %0h want fffd", insn_cnt); end
    exp_cnt = 16'hFFFD;
    for (int k = 0; k < 5; k++) begin
      checks++; if (insn_cnt !== exp_cnt || cpu_ce !== 1'b1) begin failures++; $display("FAIL wrap@%0d: got cnt=%0h ce=%0b want cnt=%0h ce=1", k, insn_cnt, cpu_ce, exp_cnt); end
      exp_cnt = exp_cnt + 16'd1;
      tick();
    end
    cmd_halt = 1'b1;
    tick();
    cmd_halt = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    cmd_run = 1'b0;
    cmd_halt = 1'b0;
    cmd_step = 1'b0;
    cmd_reset = 1'b0;
    speed_sel = 2'd0;
`ifdef TD4_BREAKPOINT_EN
    bp_en = 1'b0;
    bp_addr = 4'd0;
`endif
    test_reset();
    test_step();
    test_div_run();
    test_coincide();
    test_back_to_back();
`ifdef TD4_BREAKPOINT_EN
    test_breakpoint();
`endif
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
